// File: rtl/sobel_window_ctrl_if.sv
// Handshake bundle between the Sobel window controller and its frame driver/convolver.
interface sobel_window_ctrl_if #(
  parameter int unsigned ADDR_W = 12
) ();

  logic              start;
  logic              conv_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              win_valid;
  logic [ADDR_W-1:0] out_x;
  logic [ADDR_W-1:0] out_y;
  logic              busy;
  logic              done;

  modport master (
    output start, conv_ready,
    input  rd_en, rd_addr, win_valid, out_x, out_y, busy, done
  );

  modport slave (
    input  start, conv_ready,
    output rd_en, rd_addr, win_valid, out_x, out_y, busy, done
  );

endinterface

// File: rtl/sobel_window_ctrl.sv
// Walks a 3x3 window over the frame: 9 column-major reads, a fixed loader settle time,
// then holds the window until the convolver accepts it.
module sobel_window_ctrl #(
  parameter int unsigned IMG_W    = 64,
  parameter int unsigned IMG_H    = 64,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned LOAD_LAT = 3
) (
  input logic                clk,
  input logic                rst_n,
  sobel_window_ctrl_if.slave ctrl_if
);

  localparam logic [ADDR_W-1:0] WStep    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] XLast    = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] YLast    = ADDR_W'(IMG_H - 3);
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
  localparam logic [3:0]        WaitLast = 4'(LOAD_LAT - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StEmit, StFin} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;          // y*IMG_W + x, kept by running adds
  logic [ADDR_W-1:0] row_base_q, row_base_d;  // y*IMG_W
  logic [ADDR_W-1:0] col_addr_q, col_addr_d;  // top pixel of the column being read
  logic [1:0]        r_q, r_d, c_q, c_d;
  logic [3:0]        wait_q, wait_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              win_valid_q, win_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] next_base;
  logic              fetch;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    base_d      = base_q;
    row_base_d  = row_base_q;
    col_addr_d  = col_addr_q;
    r_d         = r_q;
    c_d         = c_q;
    wait_d      = wait_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    win_valid_d = win_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    next_base   = base_q;
    fetch       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ctrl_if.start) begin
          x_d        = '0;
          y_d        = '0;
          row_base_d = '0;
          next_base  = '0;
          busy_d     = 1'b1;
          fetch      = 1'b1;
        end
      end
      StFetch: begin
        if (r_q == 2'd2 && c_q == 2'd2) begin
          state_d = StWait;
          wait_d  = '0;
        end else if (r_q != 2'd2) begin
          rd_en_d   = 1'b1;
          r_d       = r_q + 2'd1;
          rd_addr_d = rd_addr_q + WStep;
        end else begin
          rd_en_d    = 1'b1;
          r_d        = '0;
          c_d        = c_q + 2'd1;
          col_addr_d = col_addr_q + AddrOne;
          rd_addr_d  = col_addr_q + AddrOne;
        end
      end
      StWait: begin
        if (wait_q == WaitLast) begin
          state_d     = StEmit;
          win_valid_d = 1'b1;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StEmit: begin
        if (ctrl_if.conv_ready) begin
          win_valid_d = 1'b0;
          if (x_q != XLast) begin
            x_d       = x_q + AddrOne;
            next_base = base_q + AddrOne;
            fetch     = 1'b1;
          end else if (y_q != YLast) begin
            x_d        = '0;
            y_d        = y_q + AddrOne;
            row_base_d = row_base_q + WStep;
            next_base  = row_base_q + WStep;
            fetch      = 1'b1;
          end else begin
            state_d = StFin;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Shared entry into FETCH: the first read of a window issues in the entry cycle.
    if (fetch) begin
      state_d    = StFetch;
      base_d     = next_base;
      col_addr_d = next_base;
      rd_addr_d  = next_base;
      rd_en_d    = 1'b1;
      r_d        = '0;
      c_d        = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      base_q      <= '0;
      row_base_q  <= '0;
      col_addr_q  <= '0;
      r_q         <= '0;
      c_q         <= '0;
      wait_q      <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      win_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      base_q      <= base_d;
      row_base_q  <= row_base_d;
      col_addr_q  <= col_addr_d;
      r_q         <= r_d;
      c_q         <= c_d;
      wait_q      <= wait_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      win_valid_q <= win_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ctrl_if.rd_en     = rd_en_q;
  assign ctrl_if.rd_addr   = rd_addr_q;
  assign ctrl_if.win_valid = win_valid_q;
  assign ctrl_if.out_x     = x_q;
  assign ctrl_if.out_y     = y_q;
  assign ctrl_if.busy      = busy_q;
  assign ctrl_if.done      = done_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Drives frames into the window controller and checks reads, windows, latency and
// handshakes against a raster model built from nested loops.
module tb_sobel_window_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned AW = 6;
  localparam int unsigned LL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_window_ctrl_if #(.ADDR_W(AW)) bus ();

  sobel_window_ctrl #(
    .IMG_W   (W),
    .IMG_H   (H),
    .ADDR_W  (AW),
    .LOAD_LAT(LL)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctrl_if(bus)
  );

  int checks   = 0;
  int failures = 0;
  int exp_addr[$];
  int exp_x[$];
  int exp_y[$];
  int cyc, rd_cnt, win_cnt, done_cnt, first_win_cyc, last_rd_cyc;
  bit wv_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_frame();
    exp_addr.delete();
    exp_x.delete();
    exp_y.delete();
    for (int y = 0; y <= int'(H) - 3; y++) begin
      for (int x = 0; x <= int'(W) - 3; x++) begin
        exp_x.push_back(x);
        exp_y.push_back(y);
        for (int c = 0; c < 3; c++)
          for (int r = 0; r < 3; r++)
            exp_addr.push_back((y + r) * int'(W) + x + c);
      end
    end
  endtask

  // One clock: drive inputs, account for the handshake taken at this edge, then sample.
  task automatic tick(input logic st, input logic cr);
    bus.start      = st;
    bus.conv_ready = cr;
    if (bus.win_valid && cr) begin
      win_cnt++;
      if (exp_x.size() == 0) check("extra_window", win_cnt, 0);
      else begin
        check("win_x", 32'(bus.out_x), exp_x.pop_front());
        check("win_y", 32'(bus.out_y), exp_y.pop_front());
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (bus.rd_en) begin
      rd_cnt++;
      last_rd_cyc = cyc;
      check("rd_en_with_win_valid", 32'(bus.win_valid), 0);
      if (exp_addr.size() == 0) check("extra_read", rd_cnt, 0);
      else check("rd_addr", 32'(bus.rd_addr), exp_addr.pop_front());
    end
    if (bus.win_valid && !wv_prev) begin
      if (first_win_cyc < 0) first_win_cyc = cyc;
      check("load_latency", cyc - last_rd_cyc, LL + 1);
    end
    wv_prev = bus.win_valid;
    if (bus.done) begin
      done_cnt++;
      check("busy_at_done", 32'(bus.busy), 0);
    end
  endtask

  task automatic begin_frame();
    cyc           = 0;
    rd_cnt        = 0;
    win_cnt       = 0;
    done_cnt      = 0;
    first_win_cyc = -1;
    last_rd_cyc   = 0;
    load_frame();
    tick(1'b1, 1'b0);
    check("busy_after_start", 32'(bus.busy), 1);
    check("first_rd_addr", 32'(bus.rd_addr), 0);
  endtask

  task automatic finish_frame(input int pct, input bit noise);
    int guard = 0;
    while (done_cnt == 0 && guard < 3000) begin
      tick((noise && bus.busy) ? 1'($urandom_range(0, 1)) : 1'b0,
           ($urandom_range(0, 99) < pct));
      guard++;
    end
    check("done_seen", done_cnt, 1);
    check("window_total", win_cnt, (W - 2) * (H - 2));
    check("read_total", rd_cnt, 9 * (W - 2) * (H - 2));
    check("reads_left", exp_addr.size(), 0);
    check("first_window_latency", first_win_cyc, 9 + LL + 1);
    // start presented while in FIN must not launch a frame
    tick(1'b1, 1'b1);
    check("done_one_cycle", 32'(bus.done), 0);
    check("busy_after_fin", 32'(bus.busy), 0);
    tick(1'b0, 1'b0);
    check("idle_after_fin_start", 32'(bus.busy), 0);
    check("no_read_after_fin", 32'(bus.rd_en), 0);
    check("done_count_final", done_cnt, 1);
  endtask

  initial begin
    int guard;
    bus.start      = 1'b0;
    bus.conv_ready = 1'b0;
    wv_prev        = 1'b0;
    cyc            = 0;
    rd_cnt         = 0;
    win_cnt        = 0;
    done_cnt       = 0;
    first_win_cyc  = -1;
    last_rd_cyc    = 0;

    #12;
    check("rst_rd_en", 32'(bus.rd_en), 0);
    check("rst_rd_addr", 32'(bus.rd_addr), 0);
    check("rst_win_valid", 32'(bus.win_valid), 0);
    check("rst_out_x", 32'(bus.out_x), 0);
    check("rst_out_y", 32'(bus.out_y), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with conv_ready high and no start: nothing may happen.
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1);
      check("idle_rd_en", 32'(bus.rd_en), 0);
      check("idle_busy", 32'(bus.busy), 0);
    end

    // Frame with conv_ready always high.
    begin_frame();
    finish_frame(100, 1'b0);

    // Frame with a 20-cycle stall on the first window, then start noise.
    begin_frame();
    guard = 0;
    while (!bus.win_valid && guard < 100) begin
      tick(1'b0, 1'b0);
      guard++;
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0);
      check("stall_win_valid", 32'(bus.win_valid), 1);
      check("stall_out_x", 32'(bus.out_x), exp_x[0]);
      check("stall_out_y", 32'(bus.out_y), exp_y[0]);
      check("stall_rd_en", 32'(bus.rd_en), 0);
    end
    tick(1'b0, 1'b1);
    check("resume_rd_en", 32'(bus.rd_en), 1);
    finish_frame(100, 1'b1);

    // Random backpressure with spurious starts.
    for (int f = 0; f < 3; f++) begin
      begin_frame();
      finish_frame(60, 1'b1);
    end

    // Reset during window 2 fetch.
    begin_frame();
    guard = 0;
    while (!(win_cnt == 1 && bus.rd_en) && guard < 200) begin
      tick(1'b0, 1'b1);
      guard++;
    end
    check("reached_window2_fetch", win_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rd_en", 32'(bus.rd_en), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_win_valid", 32'(bus.win_valid), 0);
    check("midrst_done", 32'(bus.done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    wv_prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1);
      check("post_rst_rd_en", 32'(bus.rd_en), 0);
      check("post_rst_busy", 32'(bus.busy), 0);
    end
    check("post_rst_no_done", done_cnt, 0);
    begin_frame();
    finish_frame(100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_window_ctrl.md
SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_W, default 64, meaning image width in pixels (>=3).
REQ-002 The block SHALL have parameter IMG_H, default 64, meaning image height in pixels (>=3).
REQ-003 The block SHALL have parameter ADDR_W, default 12, meaning pixel address width; IMG_W*IMG_H <= 2^ADDR_W.
REQ-004 The block SHALL have parameter LOAD_LAT, default 3, meaning cycles from the last rd_en to a settled 3x3 window (1..15).
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 The block SHALL have port clk, input, 1 bit, meaning the rising-edge clock.
REQ-007 The block SHALL have port rst_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-008 The block SHALL have port start, input, 1 bit, meaning a frame-start request, sampled in IDLE only.
REQ-009 The block SHALL have port conv_ready, input, 1 bit, meaning downstream convolution accepts the current window.
REQ-010 The block SHALL have port rd_en, output, 1 bit, meaning pixel-memory read strobe; it also drives the window loader enable.
REQ-011 The block SHALL have port rd_addr, output, ADDR_W bits, meaning the raster pixel address (y*IMG_W+x).
REQ-012 The block SHALL have port win_valid, output, 1 bit, meaning the window is complete and held for convolution.
REQ-013 The block SHALL have ports out_x and out_y, outputs, ADDR_W bits each, meaning the coordinates of the current window's top-left pixel.
REQ-014 The block SHALL have port busy, output, 1 bit, meaning a frame is in progress.
REQ-015 The block SHALL have port done, output, 1 bit, meaning a one-cycle frame-complete pulse.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, WAIT, EMIT and FIN.
REQ-017 In IDLE, start=1 SHALL move the FSM to FETCH, clear x and y to 0, and set busy=1 from the next cycle.
REQ-018 In FETCH, rd_en SHALL be 1 for exactly 9 consecutive cycles, then the FSM SHALL go to WAIT.
REQ-019 FETCH addresses SHALL be in column-major order: for c=0..2 (outer) and r=0..2 (inner), rd_addr=(y+r)*IMG_W+(x+c).
REQ-020 Addresses SHALL be formed with incremental adds, with no multiplier.
REQ-021 WAIT SHALL last exactly LOAD_LAT cycles with rd_en=0, then the FSM SHALL go to EMIT.
REQ-022 In EMIT, win_valid SHALL be 1 and out_x/out_y SHALL hold x/y stable until the cycle in which conv_ready=1.
REQ-023 On the EMIT handshake, x SHALL advance; at x=IMG_W-3, x SHALL wrap to 0 and y SHALL increment.
REQ-024 After the EMIT handshake, the FSM SHALL go to FETCH, or to FIN if x=IMG_W-3 and y=IMG_H-3.
REQ-025 FIN SHALL last one cycle with done=1 and busy=0, then the FSM SHALL go to IDLE.
REQ-026 The total per frame SHALL be (IMG_W-2)*(IMG_H-2) windows and 9 times that many rd_en cycles.
REQ-027 start SHALL be ignored in all states other than IDLE; start coincident with FIN SHALL have no effect.
REQ-028 conv_ready SHALL be ignored outside EMIT; conv_ready held at 1 SHALL give a window period of 9+LOAD_LAT+1 cycles.
REQ-029 rd_en SHALL never be 1 outside FETCH, so the loader's modulo-9 counter stays aligned to window boundaries.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 When rst_n=0, the block SHALL asynchronously force IDLE with rd_en=0, rd_addr=0, win_valid=0, out_x=0, out_y=0, busy=0 and done=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no done pulse, and a new start SHALL be required.
REQ-033 After reset release, the block SHALL take no action until start.

Verification
REQ-034 With IMG_W=4, IMG_H=4, LOAD_LAT=3, a start pulse and conv_ready=1 SHALL give rd_addr 0,4,8,1,5,9,2,6,10 in the first window and win_valid 13 cycles after start with out_x=0, out_y=0.
REQ-035 In the same setup, window 2 SHALL read 1,5,9,2,6,10,3,7,11 (x=1), and window 3 SHALL read 4,8,12,5,9,13,6,10,14 (x=0, y=1).
REQ-036 In the same setup, after 4 handshakes done SHALL pulse once, busy SHALL fall, and the total rd_en count SHALL be 36.
REQ-037 Holding conv_ready=0 for 20 cycles in EMIT SHALL keep win_valid=1, keep out_x/out_y constant and keep rd_en=0, with progress resuming on the first conv_ready=1.
REQ-038 A start pulse during FETCH or WAIT SHALL leave the address sequence and window count unchanged.
REQ-039 rst_n=0 during window 2 FETCH SHALL immediately give rd_en=0 and busy=0, and a new start SHALL restart at rd_addr=0.
